// File: rtl/id_stage_ctrl_pkg.sv
// Shared types for the ID stage controller.
// Holds the instruction/data word types, RV64I opcodes, immediate format
// enum, the canonical NOP encoding and the ID state encoding.
package id_stage_ctrl_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned ILEN   = 32;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned REG_W  = 5;

  typedef logic [ILEN-1:0]  inst_t;
  typedef logic [XLEN-1:0]  dw;
  typedef logic [OPC_W-1:0] opcode_t;

  localparam opcode_t OPC_LUI       = 7'b0110111;
  localparam opcode_t OPC_AUIPC     = 7'b0010111;
  localparam opcode_t OPC_JAL       = 7'b1101111;
  localparam opcode_t OPC_JALR      = 7'b1100111;
  localparam opcode_t OPC_BRANCH    = 7'b1100011;
  localparam opcode_t OPC_LOAD      = 7'b0000011;
  localparam opcode_t OPC_STORE     = 7'b0100011;
  localparam opcode_t OPC_OP_IMM    = 7'b0010011;
  localparam opcode_t OPC_OP_IMM_32 = 7'b0011011;
  localparam opcode_t OPC_OP        = 7'b0110011;
  localparam opcode_t OPC_OP_32     = 7'b0111011;
  localparam opcode_t OPC_SYSTEM    = 7'b1110011;
  localparam opcode_t OPC_MISC_MEM  = 7'b0001111;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } imm_fmt_t;

  localparam inst_t NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_VALID = 2'd1,
    ST_STALL = 2'd2
  } id_state_t;

endpackage

// File: rtl/id_stage_ctrl_imm_ext.sv
// RV64I immediate extender: sign-extends the immediate field for a format.
// Ports:
//   bits - instruction bits [31:7] (opcode bits carry no immediate)
//   fmt  - immediate format selector
//   imm  - 64-bit sign-extended immediate (0 for R-format)
module id_stage_ctrl_imm_ext
  import id_stage_ctrl_pkg::*;
(
  input  logic [31:7] bits,
  input  imm_fmt_t    fmt,
  output dw           imm
);

  // Field reassembly per RV64I encoding; sign bit is always bits[31]
  always_comb begin
    imm = '0;
    unique case (fmt)
      FMT_I:   imm = {{52{bits[31]}}, bits[31:20]};
      FMT_S:   imm = {{52{bits[31]}}, bits[31:25], bits[11:7]};
      FMT_B:   imm = {{51{bits[31]}}, bits[31], bits[7], bits[30:25], bits[11:8], 1'b0};
      FMT_U:   imm = {{32{bits[31]}}, bits[31:12], 12'b0};
      FMT_J:   imm = {{43{bits[31]}}, bits[31], bits[19:12], bits[20], bits[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_stage_ctrl.sv
// Decode-stage controller: single-entry ID pipeline register between IF and
// EX with load-use bubble insertion and front-end flush.
// Optional build macro: ID_ILLEGAL_DET_EN enables illegal-opcode detection
// (ex_illegal registered at accept); otherwise ex_illegal is tied 0.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   if_valid/if_ready        - IF handshake; if_inst/if_pc payload
//   flush                    - redirect, kills the held instruction
//   haz_ex_is_load/haz_ex_rd - EX-stage load info for load-use detection
//   ex_valid/ex_ready        - EX handshake
//   ex_inst/ex_pc/ex_imm/ex_fmt/ex_illegal - held instruction payload
module id_stage_ctrl
  import id_stage_ctrl_pkg::*;
#(
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned CNT_W        = $clog2(STALL_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  output logic        if_ready,
  input  inst_t       if_inst,
  input  dw           if_pc,
  input  logic        flush,
  input  logic        haz_ex_is_load,
  input  logic [4:0]  haz_ex_rd,
  output logic        ex_valid,
  input  logic        ex_ready,
  output inst_t       ex_inst,
  output dw           ex_pc,
  output dw           ex_imm,
  output imm_fmt_t    ex_fmt,
  output logic        ex_illegal
);

  id_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             stalled;

  imm_fmt_t fmt_c;
  dw        imm_c;
  logic     uses_rs1_c;
  logic     uses_rs2_c;
  logic     hit_c;
  logic     accept_c;

  // Immediate format of the incoming instruction; unknown opcodes fall to I
  always_comb begin
    fmt_c = FMT_I;
    unique case (if_inst[6:0])
      OPC_LUI, OPC_AUIPC: fmt_c = FMT_U;
      OPC_JAL:            fmt_c = FMT_J;
      OPC_BRANCH:         fmt_c = FMT_B;
      OPC_STORE:          fmt_c = FMT_S;
      OPC_OP, OPC_OP_32:  fmt_c = FMT_R;
      default:            fmt_c = FMT_I;
    endcase
  end

  id_stage_ctrl_imm_ext u_imm_ext (
    .bits (if_inst[31:7]),
    .fmt  (fmt_c),
    .imm  (imm_c)
  );

  // Source-register usage of the held instruction
  always_comb begin
    uses_rs1_c = 1'b1;
    uses_rs2_c = 1'b0;
    unique case (ex_inst[6:0])
      OPC_LUI, OPC_AUIPC, OPC_JAL:               uses_rs1_c = 1'b0;
      OPC_OP, OPC_OP_32, OPC_STORE, OPC_BRANCH:  uses_rs2_c = 1'b1;
      default: ;
    endcase
  end

  // Load-use hit; 'stalled' suppresses a second check of the same instruction
  assign hit_c = (state == ST_VALID) && haz_ex_is_load && (haz_ex_rd != 5'd0) && !stalled &&
                 ((uses_rs1_c && (ex_inst[19:15] == haz_ex_rd)) ||
                  (uses_rs2_c && (ex_inst[24:20] == haz_ex_rd)));

  assign ex_valid = (state == ST_VALID) && !hit_c && !flush;
  assign if_ready = !flush && ((state == ST_EMPTY) || (ex_valid && ex_ready));
  assign accept_c = if_valid && if_ready;

  // State, stall counter and payload registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_EMPTY;
      cnt     <= '0;
      stalled <= 1'b0;
      ex_inst <= NOP_INST;
      ex_pc   <= '0;
      ex_imm  <= '0;
      ex_fmt  <= FMT_I;
    end else if (flush) begin
      // Payload deliberately retained; only control state is killed
      state   <= ST_EMPTY;
      cnt     <= '0;
      stalled <= 1'b0;
    end else if (accept_c) begin
      state   <= ST_VALID;
      stalled <= 1'b0;
      ex_inst <= if_inst;
      ex_pc   <= if_pc;
      ex_imm  <= imm_c;
      ex_fmt  <= fmt_c;
    end else begin
      unique case (state)
        ST_VALID: begin
          if (ex_valid && ex_ready) begin
            state <= ST_EMPTY;
          end else if (hit_c) begin
            stalled <= 1'b1;
            // The hit cycle itself is the first bubble
            if (STALL_CYCLES == 1) begin
              state <= ST_VALID;
            end else begin
              state <= ST_STALL;
              cnt   <= CNT_W'(STALL_CYCLES - 1);
            end
          end
        end
        ST_STALL: begin
          if (cnt == CNT_W'(1)) begin
            state <= ST_VALID;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

`ifdef ID_ILLEGAL_DET_EN
  logic illegal_c;

  // Illegal when not a 32-bit encoding or opcode outside the RV64I base set
  always_comb begin
    illegal_c = 1'b1;
    unique case (if_inst[6:0])
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE,
      OPC_OP_IMM, OPC_OP_IMM_32, OPC_OP, OPC_OP_32, OPC_SYSTEM, OPC_MISC_MEM:
        illegal_c = 1'b0;
      default: illegal_c = 1'b1;
    endcase
    if (if_inst[1:0] != 2'b11) illegal_c = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_illegal <= 1'b0;
    end else if (!flush && accept_c) begin
      ex_illegal <= illegal_c;
    end
  end
`else
  assign ex_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Self-checking bench for id_stage_ctrl: directed scenarios plus randomized
// traffic checked against a transaction-level model of the ID register.
module tb_id_stage_ctrl;
  import id_stage_ctrl_pkg::*;

  localparam int unsigned STALL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  inst_t       if_inst;
  dw           if_pc;
  logic        flush;
  logic        haz_ex_is_load;
  logic [4:0]  haz_ex_rd;
  logic        ex_valid;
  logic        ex_ready;
  inst_t       ex_inst;
  dw           ex_pc;
  dw           ex_imm;
  imm_fmt_t    ex_fmt;
  logic        ex_illegal;

  id_stage_ctrl #(.STALL_CYCLES(STALL)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .flush          (flush),
    .haz_ex_is_load (haz_ex_is_load),
    .haz_ex_rd      (haz_ex_rd),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_inst        (ex_inst),
    .ex_pc          (ex_pc),
    .ex_imm         (ex_imm),
    .ex_fmt         (ex_fmt),
    .ex_illegal     (ex_illegal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int xfers    = 0;

  // Model of the ID register contents
  bit          m_known = 0;
  bit          m_held;
  bit          m_checked;
  int          m_bub;
  logic [31:0] m_inst;
  logic [63:0] m_pc;
  logic [63:0] m_imm;
  logic [2:0]  m_fmt;
  logic        m_ill;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_fmt(input logic [31:0] inst);
    case (inst[6:0])
      7'b0110111, 7'b0010111: return 3'(FMT_U);
      7'b1101111:             return 3'(FMT_J);
      7'b1100011:             return 3'(FMT_B);
      7'b0100011:             return 3'(FMT_S);
      7'b0110011, 7'b0111011: return 3'(FMT_R);
      default:                return 3'(FMT_I);
    endcase
  endfunction

  function automatic logic [63:0] ref_imm(input logic [31:0] inst);
    logic signed [11:0] v12;
    logic signed [12:0] v13;
    logic signed [20:0] v21;
    logic signed [31:0] v32;
    case (ref_fmt(inst))
      3'(FMT_I): begin v12 = inst[31:20]; return 64'(longint'(v12)); end
      3'(FMT_S): begin v12 = {inst[31:25], inst[11:7]}; return 64'(longint'(v12)); end
      3'(FMT_B): begin
        v13 = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        return 64'(longint'(v13));
      end
      3'(FMT_U): begin v32 = {inst[31:12], 12'h000}; return 64'(longint'(v32)); end
      3'(FMT_J): begin
        v21 = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        return 64'(longint'(v21));
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic ref_ill(input logic [31:0] inst);
`ifdef ID_ILLEGAL_DET_EN
    logic [6:0] op;
    op = inst[6:0];
    if (inst[1:0] != 2'b11) return 1'b1;
    return !(op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                        7'b0000011, 7'b0100011, 7'b0010011, 7'b0011011, 7'b0110011,
                        7'b0111011, 7'b1110011, 7'b0001111});
`else
    return (inst == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  function automatic bit ref_hazard(input logic [31:0] inst, input logic ld, input logic [4:0] rd);
    bit r1, r2;
    r1 = !(inst[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111});
    r2 = inst[6:0] inside {7'b0110011, 7'b0111011, 7'b0100011, 7'b1100011};
    return ld && (rd != 0) && ((r1 && inst[19:15] == rd) || (r2 && inst[24:20] == rd));
  endfunction

  // One clock of stimulus: drive, check against model, advance model
  task automatic cycle(input logic iv, input logic [31:0] inst, input logic [63:0] pc,
                       input logic er, input logic fl, input logic ld,
                       input logic [4:0] rd, input logic r,
                       output logic ev, output logic ir);
    bit hz, exp_ev, exp_ir, acc;
    @(negedge clk);
    if_valid = iv; if_inst = inst; if_pc = pc; ex_ready = er;
    flush = fl; haz_ex_is_load = ld; haz_ex_rd = rd; rst = r;
    #1;
    ev = ex_valid;
    ir = if_ready;
    hz     = m_held && !m_checked && ref_hazard(m_inst, ld, rd);
    exp_ev = m_held && (m_bub == 0) && !hz && !fl;
    exp_ir = !fl && (!m_held || (exp_ev && er));
    acc    = iv && exp_ir;
    if (m_known) begin
      check("ex_inst",    64'(ex_inst), 64'(m_inst));
      check("ex_pc",      ex_pc, m_pc);
      check("ex_imm",     ex_imm, m_imm);
      check("ex_fmt",     64'(ex_fmt), 64'(m_fmt));
      check("ex_illegal", 64'(ex_illegal), 64'(m_ill));
      check("ex_valid",   64'(ex_valid), 64'(exp_ev));
      check("if_ready",   64'(if_ready), 64'(exp_ir));
      if (exp_ev && er) xfers++;
    end
    if (r) begin
      m_known = 1; m_held = 0; m_checked = 0; m_bub = 0;
      m_inst = 32'h0000_0013; m_pc = 0; m_imm = 0; m_fmt = 3'(FMT_I); m_ill = 0;
    end else if (fl) begin
      m_held = 0; m_checked = 0; m_bub = 0;
    end else if (acc) begin
      m_held = 1; m_checked = 0; m_bub = 0;
      m_inst = inst; m_pc = pc; m_imm = ref_imm(inst); m_fmt = ref_fmt(inst); m_ill = ref_ill(inst);
    end else if (exp_ev && er) begin
      m_held = 0;
    end else if (hz) begin
      m_checked = 1;
      m_bub = int'(STALL) - 1;
    end else if (m_bub > 0) begin
      m_bub--;
    end
    @(posedge clk);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] i;
    logic [6:0]  ops [14];
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
            7'b0100011, 7'b0010011, 7'b0011011, 7'b0110011, 7'b0111011, 7'b1110011,
            7'b0001111, 7'b0000000};
    i = $urandom;
    i[19:15] = 5'($urandom_range(0, 3));
    i[24:20] = 5'($urandom_range(0, 3));
    if ($urandom_range(0, 9) != 0) i[6:0] = ops[$urandom_range(0, 13)];
    return i;
  endfunction

  logic ev, ir;
  int   x0;

  initial begin
    rst = 1; if_valid = 0; if_inst = 0; if_pc = 0; flush = 0;
    haz_ex_is_load = 0; haz_ex_rd = 0; ex_ready = 0;

    cycle(0, 0, 0, 0, 0, 0, 0, 1, ev, ir);
    #2;
    check("rst_inst",  64'(ex_inst), 64'h13);
    check("rst_valid", 64'(ex_valid), 64'd0);
    check("rst_fmt",   64'(ex_fmt), 64'(FMT_I));

    // addi x1,x0,-1 at 0x100
    cycle(1, 32'hFFF0_0093, 64'h100, 1, 0, 0, 0, 0, ev, ir);
    #2;
    check("addi_valid", 64'(ex_valid), 64'd1);
    check("addi_imm",   ex_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi_fmt",   64'(ex_fmt), 64'(FMT_I));
    check("addi_pc",    ex_pc, 64'h100);
    cycle(0, 0, 0, 1, 0, 0, 0, 0, ev, ir);

    // Stream of 4 at full rate
    x0 = xfers;
    for (int k = 0; k < 4; k++) begin
      cycle(1, 32'h0000_0013 | (32'(k + 1) << 7), 64'h200 + 64'(4 * k), 1, 0, 0, 0, 0, ev, ir);
      check("stream_ready", 64'(ir), 64'd1);
    end
    cycle(0, 0, 0, 1, 0, 0, 0, 0, ev, ir);
    check("stream_xfers", 64'(xfers - x0), 64'd4);

    // add x3,x2,x5 behind a load to x5: two bubbles then offered
    cycle(1, 32'h0051_01B3, 64'h300, 1, 0, 0, 0, 0, ev, ir);
    cycle(0, 0, 0, 1, 0, 1, 5, 0, ev, ir);
    check("lu_bub0", 64'(ev), 64'd0);
    cycle(0, 0, 0, 1, 0, 1, 5, 0, ev, ir);
    check("lu_bub1", 64'(ev), 64'd0);
    cycle(0, 0, 0, 1, 0, 1, 5, 0, ev, ir);
    check("lu_offer", 64'(ev), 64'd1);
    cycle(0, 0, 0, 1, 0, 0, 0, 0, ev, ir);
    check("lu_empty", 64'(ev), 64'd0);

    // Load to x0 never stalls
    cycle(1, 32'h0051_01B3, 64'h304, 1, 0, 0, 0, 0, ev, ir);
    cycle(0, 0, 0, 1, 0, 1, 0, 0, ev, ir);
    check("x0_nostall", 64'(ev), 64'd1);

    // lui x5,0x12345: rs1 field (8) ignored
    cycle(1, 32'h1234_52B7, 64'h308, 0, 0, 0, 0, 0, ev, ir);
    #2;
    check("lui_imm", ex_imm, 64'h0000_0000_1234_5000);
    check("lui_fmt", 64'(ex_fmt), 64'(FMT_U));
    cycle(0, 0, 0, 1, 0, 1, 8, 0, ev, ir);
    check("lui_nostall", 64'(ev), 64'd1);

    // Flush during STALL
    cycle(1, 32'h0051_01B3, 64'h400, 1, 0, 0, 0, 0, ev, ir);
    cycle(0, 0, 0, 1, 0, 1, 2, 0, ev, ir);
    cycle(0, 0, 0, 1, 1, 0, 0, 0, ev, ir);
    check("fl_valid", 64'(ev), 64'd0);
    check("fl_ready", 64'(ir), 64'd0);
    cycle(0, 0, 0, 1, 0, 0, 0, 0, ev, ir);
    check("fl_after_ready", 64'(ir), 64'd1);

    // Reset during STALL
    cycle(1, 32'h0051_01B3, 64'h500, 1, 0, 0, 0, 0, ev, ir);
    cycle(0, 0, 0, 1, 0, 1, 5, 0, ev, ir);
    cycle(0, 0, 0, 1, 0, 0, 0, 1, ev, ir);
    #2;
    check("rs_inst",  64'(ex_inst), 64'h13);
    check("rs_valid", 64'(ex_valid), 64'd0);

    // beq x0,x0,-4
    cycle(1, 32'hFE00_0EE3, 64'h600, 0, 0, 0, 0, 0, ev, ir);
    #2;
    check("beq_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    check("beq_fmt", 64'(ex_fmt), 64'(FMT_B));
    check("beq_ill", 64'(ex_illegal), 64'd0);
    cycle(0, 0, 0, 1, 0, 0, 0, 0, ev, ir);
`ifdef ID_ILLEGAL_DET_EN
    cycle(1, 32'h0000_0000, 64'h700, 0, 0, 0, 0, 0, ev, ir);
    #2;
    check("zero_ill", 64'(ex_illegal), 64'd1);
    cycle(0, 0, 0, 1, 0, 0, 0, 0, ev, ir);
`endif

    // Randomized traffic
    for (int k = 0; k < 2000; k++) begin
      cycle($urandom_range(0, 3) != 0, rand_inst(), {$urandom, $urandom},
            $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 99) == 0, ev, ir);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
